game_stopwatch: RTL and testbench

Free-running mm:ss BCD stopwatch for the Bop-it design, sitting directly upstream of the anode/digit multiplexer. Produces the live time digits and a lap-captured copy of them: the live set feeds the stopwatch display mode, the lap set feeds the second-time display mode. Start, stop, clear and lap arrive as one-cycle pulses from the button debounce/edge stage; an internal prescaler turns the 100 MHz board clock into one-second increments.

---
 rtl/game_stopwatch.sv | 140 ++++++++++++++
 tb/tb_game_stopwatch.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/game_stopwatch.sv
// mm:ss BCD stopwatch with lap capture, driven by start/stop/clear/lap pulses.
// A prescaler divides clk down to one-second increments while running.
module game_stopwatch #(
  parameter int unsigned TICKS_PER_SEC = 100_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  input  logic       lap,
  output logic [3:0] sec1,
  output logic [3:0] sec2,
  output logic [3:0] min1,
  output logic [3:0] min2,
  output logic [3:0] sec11,
  output logic [3:0] sec22,
  output logic [3:0] min11,
  output logic [3:0] min22,
  output logic       running,
  output logic       sec_tick,
  output logic       wrap
);

  localparam int unsigned PW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2
  } state_t;

  state_t        state, next_state;
  logic [PW-1:0] presc, presc_n;
  logic [3:0]    sec1_n, sec2_n, min1_n, min2_n;
  logic          inc;
  logic          wrap_n;

  // NOTE: every sequential element uses non-blocking (<=) so all registers
  // update from the same pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Priority: clear > stop > start; stop beats a simultaneous start.
  always_comb begin
    // NOTE: default assignment first so no path leaves next_state unassigned,
    // which would otherwise infer a latch.
    next_state = state;
    unique case (state)
      IDLE:    if (start && !stop) next_state = RUN;
      RUN:     if (stop)           next_state = PAUSED;
      PAUSED:  if (start && !stop) next_state = RUN;
      default:                     next_state = IDLE;
    endcase
    if (clear) next_state = IDLE;
  end

  // An increment still completes on a stop edge; clear suppresses it.
  assign inc = (state == RUN) && (presc == PRESC_LAST) && !clear;

  always_comb begin
    presc_n = presc;
    if (clear)              presc_n = '0;
    else if (state == RUN)  presc_n = (presc == PRESC_LAST) ? '0 : presc + PW'(1);
  end

  // BCD ripple: each digit rolls over only when all lower digits roll over.
  always_comb begin
    sec1_n = sec1;
    sec2_n = sec2;
    min1_n = min1;
    min2_n = min2;
    wrap_n = 1'b0;
    if (clear) begin
      sec1_n = 4'd0;
      sec2_n = 4'd0;
      min1_n = 4'd0;
      min2_n = 4'd0;
    end else if (inc) begin
      if (sec1 != 4'd9) sec1_n = sec1 + 4'd1;
      else begin
        sec1_n = 4'd0;
        if (sec2 != 4'd5) sec2_n = sec2 + 4'd1;
        else begin
          sec2_n = 4'd0;
          if (min1 != 4'd9) min1_n = min1 + 4'd1;
          else begin
            min1_n = 4'd0;
            if (min2 != 4'd5) min2_n = min2 + 4'd1;
            else begin
              min2_n = 4'd0;
              wrap_n = 1'b1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc    <= '0;
      sec1     <= 4'd0;
      sec2     <= 4'd0;
      min1     <= 4'd0;
      min2     <= 4'd0;
      sec_tick <= 1'b0;
      wrap     <= 1'b0;
    end else begin
      presc    <= presc_n;
      sec1     <= sec1_n;
      sec2     <= sec2_n;
      min1     <= min1_n;
      min2     <= min2_n;
      sec_tick <= inc;
      wrap     <= wrap_n;
    end
  end

  // Lap copies the registered (pre-increment) digits; only reset clears it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sec11 <= 4'd0;
      sec22 <= 4'd0;
      min11 <= 4'd0;
      min22 <= 4'd0;
    end else if (lap) begin
      sec11 <= sec1;
      sec22 <= sec2;
      min11 <= min1;
      min22 <= min2;
    end
  end

  assign running = (state == RUN);

endmodule

// File: tb/tb_game_stopwatch.sv
// Scoreboard bench for game_stopwatch at TICKS_PER_SEC=4: stimulus pushes the
// expected time for each increment, a monitor pops it whenever sec_tick fires.
module tb_game_stopwatch;

  localparam int TPS = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, stop = 1'b0, clear = 1'b0, lap = 1'b0;
  logic [3:0] sec1, sec2, min1, min2, sec11, sec22, min11, min22;
  logic       running, sec_tick, wrap;

  typedef struct packed {
    logic [15:0] digits;
    logic        wrap;
  } tick_exp_t;

  tick_exp_t exp_q[$];
  int total = 0;
  int bad = 0;
  int model_sec = 0;
  int pushed = 0;
  int tick_count = 0;

  game_stopwatch #(.TICKS_PER_SEC(TPS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .clear(clear), .lap(lap),
    .sec1(sec1), .sec2(sec2), .min1(min1), .min2(min2),
    .sec11(sec11), .sec22(sec22), .min11(min11), .min22(min22),
    .running(running), .sec_tick(sec_tick), .wrap(wrap)
  );

  always #5 clk = ~clk;

  wire [15:0] live_d = {min2, min1, sec2, sec1};
  wire [15:0] lap_d  = {min22, min11, sec22, sec11};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int s);
    int m = s / 60;
    int r = s % 60;
    return {4'(m / 10), 4'(m % 10), 4'(r / 10), 4'(r % 10)};
  endfunction

  task automatic push_ticks(input int n);
    tick_exp_t e;
    for (int i = 0; i < n; i++) begin
      model_sec = (model_sec + 1) % 3600;
      e.digits  = to_bcd(model_sec);
      e.wrap    = (model_sec == 0);
      exp_q.push_back(e);
      pushed++;
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic run_ticks(input int n);
    push_ticks(n);
    cycles(n * TPS);
  endtask

  // Monitor: each sec_tick cycle must match the oldest expected increment.
  initial begin
    tick_exp_t e;
    forever begin
      @(negedge clk);
      if (sec_tick === 1'b1) begin
        tick_count++;
        if (exp_q.size() == 0) begin
          check("unexpected_tick", {16'd0, live_d}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("tick_digits", {16'd0, live_d}, {16'd0, e.digits});
          check("tick_wrap", {31'd0, wrap}, {31'd0, e.wrap});
          check("tick_running", {31'd0, running}, 32'd1);
        end
      end else if (wrap !== 1'b0) begin
        check("wrap_without_tick", {31'd0, wrap}, 32'd0);
      end
    end
  end

  initial begin
    // Reset state
    cycles(2);
    check("rst_live", {16'd0, live_d}, 32'h0);
    check("rst_lap", {16'd0, lap_d}, 32'h0);
    check("rst_flags", {29'd0, running, sec_tick, wrap}, 32'd0);
    rst_n = 1'b1;
    cycles(1);

    // Ten increments from start
    start = 1'b1; cycles(1); start = 1'b0;
    check("start_running", {31'd0, running}, 32'd1);
    run_ticks(10);
    check("ten_secs", {16'd0, live_d}, 32'h0010);
    check("ten_ticks", tick_count, 10);

    // Minute carry at 09:59 and wrap at 59:59
    run_ticks(589);
    check("at_0959", {16'd0, live_d}, 32'h0959);
    run_ticks(1);
    check("at_1000", {16'd0, live_d}, 32'h1000);
    run_ticks(2999);
    check("at_5959", {16'd0, live_d}, 32'h5959);
    run_ticks(1);
    check("wrap_flag", {31'd0, wrap}, 32'd1);
    check("wrap_running", {31'd0, running}, 32'd1);
    check("wrap_0000", {16'd0, live_d}, 32'h0000);

    // Lap on the increment edge 00:07 -> 00:08
    run_ticks(7);
    push_ticks(1);
    cycles(3);
    lap = 1'b1; cycles(1); lap = 1'b0;
    check("lap_pre_inc", {16'd0, lap_d}, 32'h0007);
    check("live_post_inc", {16'd0, live_d}, 32'h0008);

    // Pause holds the prescaler at 2; resume increments 2 cycles later
    cycles(1);
    stop = 1'b1; cycles(1); stop = 1'b0;
    check("stop_running", {31'd0, running}, 32'd0);
    cycles(20);
    check("paused_hold", {16'd0, live_d}, 32'h0008);
    start = 1'b1; cycles(1); start = 1'b0;
    check("resume_running", {31'd0, running}, 32'd1);
    cycles(1);
    check("resume_no_tick_yet", {31'd0, sec_tick}, 32'd0);
    push_ticks(1);
    cycles(1);
    check("resume_inc", {16'd0, live_d}, 32'h0009);

    // start+stop together from PAUSED stays paused
    stop = 1'b1; cycles(1); stop = 1'b0;
    start = 1'b1; stop = 1'b1; cycles(1); start = 1'b0; stop = 1'b0;
    check("startstop_paused", {31'd0, running}, 32'd0);
    check("startstop_hold", {16'd0, live_d}, 32'h0009);

    // clear+stop+start in RUN -> IDLE, lap untouched
    start = 1'b1; cycles(1); start = 1'b0;
    check("rerun", {31'd0, running}, 32'd1);
    clear = 1'b1; stop = 1'b1; start = 1'b1; cycles(1);
    clear = 1'b0; stop = 1'b0; start = 1'b0;
    model_sec = 0;
    check("clear_running", {31'd0, running}, 32'd0);
    check("clear_live", {16'd0, live_d}, 32'h0000);
    check("clear_keeps_lap", {16'd0, lap_d}, 32'h0007);

    // clear on the increment edge suppresses the increment
    start = 1'b1; cycles(1); start = 1'b0;
    cycles(3);
    clear = 1'b1; cycles(1); clear = 1'b0;
    check("clear_inc_tick", {31'd0, sec_tick}, 32'd0);
    check("clear_inc_live", {16'd0, live_d}, 32'h0000);
    check("clear_inc_running", {31'd0, running}, 32'd0);

    // Reset mid-run at 03:42 with lap 03:10, on an increment edge
    start = 1'b1; cycles(1); start = 1'b0;
    run_ticks(190);
    lap = 1'b1; cycles(1); lap = 1'b0;
    check("lap_0310", {16'd0, lap_d}, 32'h0310);
    push_ticks(32);
    cycles(32 * TPS - 1);
    check("at_0342", {16'd0, live_d}, 32'h0342);
    cycles(3);
    rst_n = 1'b0; lap = 1'b1; start = 1'b1;
    cycles(1);
    check("mid_rst_live", {16'd0, live_d}, 32'h0);
    check("mid_rst_lap", {16'd0, lap_d}, 32'h0);
    check("mid_rst_flags", {29'd0, running, sec_tick, wrap}, 32'd0);
    lap = 1'b0; start = 1'b0; rst_n = 1'b1;
    cycles(2);

    check("queue_drained", exp_q.size(), 0);
    check("tick_total", tick_count, pushed);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
